// File: rtl/iq_demod_pkg.sv
// Shared types and constants for the IQ mix-and-accumulate demodulator.
package iq_demod_pkg;

  // 2-bit two's-complement carrier coefficient; code 2'b10 is treated as zero
  typedef logic [1:0] coef_t;

  localparam coef_t COEF_POS  = 2'b01;
  localparam coef_t COEF_ZERO = 2'b00;
  localparam coef_t COEF_NEG  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  // Accumulator width that cannot wrap over a full window of products
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned acc_len);
    return data_w + 1 + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/iq_mix_coef.sv
// Combinational multiply of a signed sample by a {-1,0,+1} coefficient.
// The result is one bit wider than the sample so that negating the most
// negative input is exact.
module iq_mix_coef
  import iq_demod_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic signed [DATA_W-1:0] sample,
  input  coef_t                    coef,
  output logic signed [DATA_W:0]   prod_c
);

  logic signed [DATA_W:0] ext;

  // Sign-extend, then select +x, -x or 0
  always_comb begin
    ext    = {sample[DATA_W-1], sample};
    prod_c = '0;
    case (coef)
      COEF_POS: prod_c = ext;
      COEF_NEG: prod_c = -ext;
      default:  prod_c = '0;
    endcase
  end

endmodule

// File: rtl/iq_mix_acc.sv
// IQ mixer with integrate-and-dump accumulators and a one-deep output holding
// register with valid/ready handshake and sticky overrun flag.
// Optional feature: define IQ_MIX_SAT_EN to clamp window sums to the OUT_W
// range; otherwise outputs are the low OUT_W bits of the sums.
module iq_mix_acc
  import iq_demod_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_LEN = 20,
  parameter int unsigned OUT_W   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic [1:0]               cosine_in,
  input  logic [1:0]               sine_in,
  output logic signed [OUT_W-1:0]  i_out,
  output logic signed [OUT_W-1:0]  q_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overrun
);

  localparam int unsigned PROD_W = DATA_W + 1;
  localparam int unsigned ACC_W  = acc_width(DATA_W, ACC_LEN);
  localparam int unsigned CNT_W  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

`ifdef IQ_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);
`endif

  // Window sum to output format
  function automatic logic signed [OUT_W-1:0] to_out(input logic signed [ACC_W-1:0] s);
`ifdef IQ_MIX_SAT_EN
    if (s > SAT_MAX)      return {1'b0, {(OUT_W-1){1'b1}}};
    else if (s < SAT_MIN) return {1'b1, {(OUT_W-1){1'b0}}};
    else                  return OUT_W'(s);
`else
    return OUT_W'(s);
`endif
  endfunction

  logic signed [PROD_W-1:0] prod_i_c, prod_q_c;
  logic signed [PROD_W-1:0] prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic                     prod_vld_q, prod_vld_d;
  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0]  base_i, base_q;
  logic                     dump_q, dump_d;
  logic signed [OUT_W-1:0]  i_out_q, i_out_d, q_out_q, q_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overrun_q, overrun_d;

  iq_mix_coef #(.DATA_W(DATA_W)) u_mix_i (
    .sample (sample_in),
    .coef   (cosine_in),
    .prod_c (prod_i_c)
  );

  iq_mix_coef #(.DATA_W(DATA_W)) u_mix_q (
    .sample (sample_in),
    .coef   (sine_in),
    .prod_c (prod_q_c)
  );

  // Next-state: mix register, FSM, accumulators, dump and output handshake
  always_comb begin
    prod_i_d    = prod_i_q;
    prod_q_d    = prod_q_q;
    prod_vld_d  = en && sample_valid;
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    dump_d      = 1'b0;
    i_out_d     = i_out_q;
    q_out_d     = q_out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (en && sample_valid) begin
      prod_i_d = prod_i_c;
      prod_q_d = prod_q_c;
    end

    // A completed window restarts from zero the cycle its sums are dumped
    base_i = dump_q ? '0 : acc_i_q;
    base_q = dump_q ? '0 : acc_q_q;

    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          acc_i_d = '0;
          acc_q_d = '0;
        end else begin
          acc_i_d = base_i;
          acc_q_d = base_q;
          if (prod_vld_q) begin
            acc_i_d = base_i + ACC_W'(prod_i_q);
            acc_q_d = base_q + ACC_W'(prod_q_q);
            if (cnt_q == CNT_LAST) begin
              cnt_d  = '0;
              dump_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register: new result wins over acceptance of the old one
    if (dump_q) begin
      i_out_d     = to_out(acc_i_q);
      q_out_d     = to_out(acc_q_q);
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (resetn) begin
      prod_i_q    <= '0;
      prod_q_q    <= '0;
      prod_vld_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      dump_q      <= 1'b0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      prod_i_q    <= prod_i_d;
      prod_q_q    <= prod_q_d;
      prod_vld_q  <= prod_vld_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      dump_q      <= dump_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_iq_mix_acc.sv
// Scoreboard bench for iq_mix_acc: directed windows push expected sums, a
// negedge monitor pops and compares on every accepted result.
module tb_iq_mix_acc;

  logic              clk = 1'b0;
  logic              resetn;
  logic              en;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic [1:0]        cosine_in;
  logic [1:0]        sine_in;
  logic signed [11:0] i_out;
  logic signed [11:0] q_out;
  logic              out_valid;
  logic              out_ready;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int exp_i_q[$];
  int exp_q_q[$];

  iq_mix_acc #(.DATA_W(8), .ACC_LEN(20), .OUT_W(12)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .cosine_in    (cosine_in),
    .sine_in      (sine_in),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_result(input int ei, input int eq);
    exp_i_q.push_back(ei);
    exp_q_q.push_back(eq);
  endtask

  // Drive n valid samples; with gap=1 an invalid cycle with junk data follows each
  task automatic drive_window(input int n, input logic signed [7:0] s,
                              input logic [1:0] c, input logic [1:0] sn,
                              input bit gap);
    for (int k = 0; k < n; k++) begin
      sample_in    = s;
      cosine_in    = c;
      sine_in      = sn;
      sample_valid = 1'b1;
      tick();
      if (gap) begin
        sample_valid = 1'b0;
        sample_in    = 8'sd127;
        tick();
      end
    end
    sample_valid = 1'b0;
  endtask

  // Monitor: compare every accepted result against the scoreboard
  always @(negedge clk) begin
    if (!resetn && out_valid && out_ready) begin
      pulses++;
      if (exp_i_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got i=%0d q=%0d expected none", i_out, q_out);
      end else begin
        chk("result_i", int'(i_out), exp_i_q.pop_front());
        chk("result_q", int'(q_out), exp_q_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sat_exp;
    resetn = 1'b1; en = 1'b1; sample_in = 8'sd50; sample_valid = 1'b1;
    cosine_in = 2'b01; sine_in = 2'b01; out_ready = 1'b0;
    tick(); tick(); tick();
    chk("reset_i", int'(i_out), 0);
    chk("reset_q", int'(q_out), 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_overrun", int'(overrun), 0);

    resetn = 1'b0; sample_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
    tick();

    // Basic window and latency
    expect_result(200, 0);
    drive_window(20, 8'sd10, 2'b01, 2'b00, 1'b0);
    tick();
    chk("lat_cycle1_valid", int'(out_valid), 0);
    tick();
    chk("lat_cycle2_valid", int'(out_valid), 1);
    tick();
    chk("after_accept_valid", int'(out_valid), 0);
    chk("t1_pulses", pulses, 1);

    // Full-scale negative samples times -1 on both rails
`ifdef IQ_MIX_SAT_EN
    sat_exp = 2047;
`else
    sat_exp = -1536;
`endif
    expect_result(sat_exp, sat_exp);
    drive_window(20, -8'sd128, 2'b11, 2'b11, 1'b0);
    repeat (4) tick();

    // Held result and overrun over two windows
    out_ready = 1'b0;
    drive_window(20, 8'sd1, 2'b01, 2'b00, 1'b0);
    repeat (3) tick();
    chk("hold1_valid", int'(out_valid), 1);
    chk("hold1_i", int'(i_out), 20);
    chk("hold1_overrun", int'(overrun), 0);
    drive_window(20, 8'sd1, 2'b01, 2'b00, 1'b0);
    repeat (3) tick();
    chk("hold2_i", int'(i_out), 20);
    chk("hold2_overrun", int'(overrun), 1);
    expect_result(20, 0);
    out_ready = 1'b1;
    tick();
    chk("hold_release_valid", int'(out_valid), 0);
    chk("overrun_sticky", int'(overrun), 1);

    // Enable dropped mid-window discards the partial sums
    drive_window(7, 8'sd3, 2'b01, 2'b11, 1'b0);
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    expect_result(60, -60);
    drive_window(20, 8'sd3, 2'b01, 2'b11, 1'b0);
    repeat (4) tick();

    // Reset mid-window while a result is pending
    out_ready = 1'b0;
    drive_window(20, 8'sd2, 2'b01, 2'b01, 1'b0);
    repeat (3) tick();
    chk("pre_reset_valid", int'(out_valid), 1);
    drive_window(5, 8'sd9, 2'b01, 2'b01, 1'b0);
    sample_valid = 1'b1;
    resetn = 1'b1;
    tick();
    chk("midreset_i", int'(i_out), 0);
    chk("midreset_q", int'(q_out), 0);
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_overrun", int'(overrun), 0);
    resetn = 1'b0;
    sample_valid = 1'b0;
    out_ready = 1'b1;
    expect_result(80, -80);
    drive_window(20, 8'sd4, 2'b01, 2'b11, 1'b0);
    repeat (4) tick();

    // Alternating valid/invalid samples
    expect_result(100, 0);
    drive_window(20, 8'sd5, 2'b01, 2'b00, 1'b1);

    for (int w = 0; w < 20 && exp_i_q.size() != 0; w++) tick();
    chk("scoreboard_drained", exp_i_q.size(), 0);
    chk("total_pulses", pulses, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
